// File: rtl/edge_accel_ctrl_v2.sv
// edge_accel_ctrl_v2: Avalon-MM register file plus pixel engine that streams
// WIDTH*HEIGHT pixels from SRC_BASE, applies copy/invert/threshold, writes to DST_BASE.
// Optional feature macro: EDGE_ACCEL_IRQ_EN (adds irq port and IRQ_EN register 11).
// Ports:
//   csi_clock_clk / csi_clock_reset : clock, synchronous active-high reset
//   avs_avalonslave_*               : register slave (address, read, write, readdata, writedata, waitrequest=0)
//   avm_avalonmaster_*              : pixel master (address, read, write, readdata, writedata, waitrequest)
//   irq                             : level interrupt, only with EDGE_ACCEL_IRQ_EN
module edge_accel_ctrl_v2 #(
    parameter int AVS_DATA_W = 16,
    parameter int AVS_ADDR_W = 4,
    parameter int AVM_DATA_W = 8,
    parameter int AVM_ADDR_W = 32
) (
    input  logic                  csi_clock_clk,
    input  logic                  csi_clock_reset,
    input  logic [AVS_ADDR_W-1:0] avs_avalonslave_address,
    output logic                  avs_avalonslave_waitrequest,
    input  logic                  avs_avalonslave_read,
    input  logic                  avs_avalonslave_write,
    output logic [AVS_DATA_W-1:0] avs_avalonslave_readdata,
    input  logic [AVS_DATA_W-1:0] avs_avalonslave_writedata,
    output logic [AVM_ADDR_W-1:0] avm_avalonmaster_address,
    input  logic                  avm_avalonmaster_waitrequest,
    output logic                  avm_avalonmaster_read,
    output logic                  avm_avalonmaster_write,
    input  logic [AVM_DATA_W-1:0] avm_avalonmaster_readdata,
    output logic [AVM_DATA_W-1:0] avm_avalonmaster_writedata
`ifdef EDGE_ACCEL_IRQ_EN
    ,
    output logic                  irq
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    localparam logic [31:0] BYTES = 32'(AVM_DATA_W / 8);

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d, job_mode_q, job_mode_d;
    logic                  done_q, done_d, aborted_q, aborted_d, abort_pend_q, abort_pend_d;
    logic [31:0]           src_q, src_d, dst_q, dst_d, pix_done_q, pix_done_d, idx_q, idx_d;
    logic [15:0]           width_q, width_d, height_q, height_d, thresh_q, thresh_d;
    logic [AVM_DATA_W-1:0] wdata_q, wdata_d;

    logic [15:0]           we;
    logic [15:0]           wd;
    logic                  busy, go, abort_req, cfg_we, done_set, ab_set;
    logic [1:0]            w1c;
    logic [31:0]           total, off;
    logic [AVM_DATA_W-1:0] thr, proc, pix;
    logic [AVS_DATA_W-1:0] rdata;
    logic                  unused;

    assign wd = avs_avalonslave_writedata;
    assign busy = state_q != S_IDLE;
    assign we = avs_avalonslave_write ? 16'(1) << avs_avalonslave_address : 16'h0;
    assign unused = &{1'b0, avs_avalonslave_read, we, thresh_q};

    always_ff @(posedge csi_clock_clk) begin
        if (csi_clock_reset) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            job_mode_q   <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            pix_done_q   <= '0;
            idx_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            thresh_q     <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            job_mode_q   <= job_mode_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            pix_done_q   <= pix_done_d;
            idx_q        <= idx_d;
            width_q      <= width_d;
            height_q     <= height_d;
            thresh_q     <= thresh_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        cfg_we    = !busy;
        mode_d    = we[0] ? wd[3:2] : mode_q;
        go        = we[0] & wd[0] & ~wd[1];
        abort_req = we[0] & wd[1] & busy;
        w1c       = we[1] ? wd[2:1] : 2'b00;
        src_d     = src_q;
        dst_d     = dst_q;
        if (cfg_we && we[2]) src_d[15:0]  = wd;
        if (cfg_we && we[3]) src_d[31:16] = wd;
        if (cfg_we && we[4]) dst_d[15:0]  = wd;
        if (cfg_we && we[5]) dst_d[31:16] = wd;
        width_d  = (cfg_we && we[6]) ? wd : width_q;
        height_d = (cfg_we && we[7]) ? wd : height_q;
        thresh_d = (cfg_we && we[8]) ? wd : thresh_q;
        total    = {16'h0, width_q} * {16'h0, height_q};
        thr      = AVM_DATA_W'(thresh_q);
        pix      = avm_avalonmaster_readdata;
        proc     = job_mode_q == 2'd1 ? ~pix : job_mode_q == 2'd2 ? ((pix >= thr) ? '1 : '0) : pix;
        state_d      = state_q;
        idx_d        = idx_q;
        pix_done_d   = pix_done_q;
        wdata_d      = wdata_q;
        job_mode_d   = job_mode_q;
        abort_pend_d = abort_pend_q | abort_req;
        done_set     = 1'b0;
        ab_set       = 1'b0;
        case (state_q)
            S_IDLE: if (go) begin
                if (total == 32'd0) done_set = 1'b1;
                else begin
                    state_d      = S_RD;
                    idx_d        = '0;
                    pix_done_d   = '0;
                    job_mode_d   = mode_d;
                    abort_pend_d = 1'b0;
                end
            end
            S_RD: if (!avm_avalonmaster_waitrequest) begin
                wdata_d = proc;
                ab_set  = abort_pend_d;
                state_d = abort_pend_d ? S_IDLE : S_WR;
            end
            S_WR: if (!avm_avalonmaster_waitrequest) begin
                idx_d      = idx_q + 32'd1;
                pix_done_d = pix_done_q + 32'd1;
                ab_set     = abort_pend_d;
                done_set   = !abort_pend_d && idx_d == total;
                state_d    = (abort_pend_d || idx_d == total) ? S_IDLE : S_RD;
            end
            default: state_d = S_IDLE;
        endcase
        // a pending abort only lives for the job it was raised in
        if (state_d == S_IDLE) abort_pend_d = 1'b0;
        // set beats a same-cycle W1C
        done_d    = (done_q & ~w1c[0]) | done_set;
        aborted_d = (aborted_q & ~w1c[1]) | ab_set;
    end

    always_comb begin
        off                      = idx_q * BYTES;
        avm_avalonmaster_read    = state_q == S_RD;
        avm_avalonmaster_write   = state_q == S_WR;
        avm_avalonmaster_address = avm_avalonmaster_read  ? AVM_ADDR_W'(src_q + off) :
                                   avm_avalonmaster_write ? AVM_ADDR_W'(dst_q + off) : '0;
    end

    assign avm_avalonmaster_writedata  = wdata_q;
    assign avs_avalonslave_waitrequest = 1'b0;

`ifdef EDGE_ACCEL_IRQ_EN
    logic [1:0] irq_en_q, irq_en_d;
    logic       irq_q, irq_d;

    always_comb begin
        irq_en_d = we[11] ? wd[1:0] : irq_en_q;
        // built from next-state values so irq moves on the same edge as the status bits
        irq_d    = (done_d & irq_en_d[0]) | (aborted_d & irq_en_d[1]);
    end

    always_ff @(posedge csi_clock_clk) begin
        if (csi_clock_reset) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        rdata = '0;
        case (int'(avs_avalonslave_address))
            0:  rdata = {12'h0, mode_q, 2'b00};
            1:  rdata = {13'h0, aborted_q, done_q, busy};
            2:  rdata = src_q[15:0];
            3:  rdata = src_q[31:16];
            4:  rdata = dst_q[15:0];
            5:  rdata = dst_q[31:16];
            6:  rdata = width_q;
            7:  rdata = height_q;
            8:  rdata = thresh_q;
            9:  rdata = pix_done_q[15:0];
            10: rdata = pix_done_q[31:16];
`ifdef EDGE_ACCEL_IRQ_EN
            11: rdata = {14'h0, irq_en_q};
`endif
            default: rdata = '0;
        endcase
    end

    assign avs_avalonslave_readdata = rdata;
endmodule

// File: tb/tb_edge_accel_ctrl_v2.sv
// tb_edge_accel_ctrl_v2: directed bench for edge_accel_ctrl_v2 (8-bit and 32-bit pixel instances).
module tb_edge_accel_ctrl_v2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  s_addr = '0;
    logic        s_rd = 1'b0, s_wr = 1'b0;
    logic [15:0] s_wd = '0;
    logic [15:0] s_rdata, s_rdata32;
    logic        s_wait, s_wait32;
    logic [31:0] m_addr, m32_addr, m32_rdata, m32_wdata;
    logic        m_wait, m_rd, m_wr, m32_rd, m32_wr;
    logic [7:0]  m_rdata, m_wdata;
`ifdef EDGE_ACCEL_IRQ_EN
    logic        irq, irq32;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem [0:65535];
    logic [31:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [31:0] rd_addr_q[$];
    logic [31:0] w32_addr_q[$];
    logic [31:0] w32_data_q[$];
    int          strobes = 0;
    int          stall_viol = 0;
    logic        force_wait = 1'b0, stall_en = 1'b0, stall_wait = 1'b0;

    assign m_wait    = force_wait | stall_wait;
    assign m_rdata   = mem[m_addr[15:0]];
    assign m32_rdata = {m32_addr[15:0], 16'hBEEF};

    edge_accel_ctrl_v2 dut (
        .csi_clock_clk(clk), .csi_clock_reset(rst),
        .avs_avalonslave_address(s_addr), .avs_avalonslave_waitrequest(s_wait),
        .avs_avalonslave_read(s_rd), .avs_avalonslave_write(s_wr),
        .avs_avalonslave_readdata(s_rdata), .avs_avalonslave_writedata(s_wd),
        .avm_avalonmaster_address(m_addr), .avm_avalonmaster_waitrequest(m_wait),
        .avm_avalonmaster_read(m_rd), .avm_avalonmaster_write(m_wr),
        .avm_avalonmaster_readdata(m_rdata), .avm_avalonmaster_writedata(m_wdata)
`ifdef EDGE_ACCEL_IRQ_EN
        , .irq(irq)
`endif
    );

    edge_accel_ctrl_v2 #(.AVM_DATA_W(32)) dut32 (
        .csi_clock_clk(clk), .csi_clock_reset(rst),
        .avs_avalonslave_address(s_addr), .avs_avalonslave_waitrequest(s_wait32),
        .avs_avalonslave_read(s_rd), .avs_avalonslave_write(s_wr),
        .avs_avalonslave_readdata(s_rdata32), .avs_avalonslave_writedata(s_wd),
        .avm_avalonmaster_address(m32_addr), .avm_avalonmaster_waitrequest(1'b0),
        .avm_avalonmaster_read(m32_rd), .avm_avalonmaster_write(m32_wr),
        .avm_avalonmaster_readdata(m32_rdata), .avm_avalonmaster_writedata(m32_wdata)
`ifdef EDGE_ACCEL_IRQ_EN
        , .irq(irq32)
`endif
    );

    // Slave model for the 8-bit master: decides waitrequest at negedge for the
    // coming posedge, logs transfers that will be accepted, and checks stability.
    int          cnt = 0;
    bit          active = 1'b0, prev_stalled = 1'b0, w;
    logic        p_rd, p_wr;
    logic [31:0] p_addr;
    logic [7:0]  p_wd;
    always @(negedge clk) begin
        if (prev_stalled && (m_rd !== p_rd || m_wr !== p_wr || m_addr !== p_addr || m_wdata !== p_wd))
            stall_viol++;
        if (!rst && (m_rd || m_wr)) begin
            strobes++;
            if (!active) begin
                cnt = stall_en ? int'($urandom_range(0, 5)) : 0;
                active = 1'b1;
            end
            stall_wait = cnt != 0;
            if (cnt != 0) cnt--;
            w = force_wait | stall_wait;
            if (!w) begin
                active = 1'b0;
                if (m_rd) rd_addr_q.push_back(m_addr);
                if (m_wr) begin
                    wr_addr_q.push_back(m_addr);
                    wr_data_q.push_back(m_wdata);
                    mem[m_addr[15:0]] = m_wdata;
                end
            end
            prev_stalled = w;
        end else begin
            stall_wait = 1'b0;
            active = 1'b0;
            prev_stalled = 1'b0;
        end
        p_rd = m_rd; p_wr = m_wr; p_addr = m_addr; p_wd = m_wdata;
    end

    always @(negedge clk) begin
        if (!rst && m32_wr) begin
            w32_addr_q.push_back(m32_addr);
            w32_data_q.push_back(m32_wdata);
        end
    end

    task automatic reg_wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        s_addr = a; s_wd = d; s_wr = 1'b1;
        @(negedge clk);
        s_wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [3:0] a, output logic [15:0] d);
        s_addr = a;
        #1 d = s_rdata;
    endtask

    task automatic cfg(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] wdt, input logic [15:0] hgt);
        reg_wr(2, src[15:0]); reg_wr(3, src[31:16]);
        reg_wr(4, dst[15:0]); reg_wr(5, dst[31:16]);
        reg_wr(6, wdt); reg_wr(7, hgt);
        reg_wr(1, 16'h0006);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        w32_addr_q.delete(); w32_data_q.delete();
    endtask

    task automatic wait_idle(input int maxc, output int n);
        logic [15:0] st;
        n = 0;
        reg_rd(1, st);
        while (st[0] && n < maxc) begin
            n++;
            @(negedge clk);
            reg_rd(1, st);
        end
        if (st[0]) begin fails++; $display("FAIL wait_idle: still busy after %0d cycles", n); end
        tests++;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        for (int i = 0; i < 12; i++) begin
            reg_rd(4'(i), v);
            if (v !== 16'h0) begin fails++; $display("FAIL reset_reg%0d: got %h exp 0000", i, v); end
            tests++;
        end
        if ({m_rd, m_wr} !== 2'b00) begin fails++; $display("FAIL reset_strobes: got %b exp 00", {m_rd, m_wr}); end
        tests++;
        if (m_addr !== 32'h0 || m_wdata !== 8'h0) begin fails++; $display("FAIL reset_bus: got %h/%h exp 0/0", m_addr, m_wdata); end
        tests++;
`ifdef EDGE_ACCEL_IRQ_EN
        if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b exp 0", irq); end
        tests++;
`endif
    endtask

    task automatic test_copy;
        logic [15:0] v;
        int n;
        for (int i = 0; i < 8; i++) mem[16'h1000 + 16'(i)] = 8'(17 * (i + 1));
        cfg(32'h1000, 32'h2000, 16'd4, 16'd2);
        reg_wr(0, 16'h0001);
        wait_idle(100, n);
        if (n !== 16) begin fails++; $display("FAIL copy_cycles: got %0d exp 16", n); end
        tests++;
        reg_rd(1, v);
        if (v !== 16'h0002) begin fails++; $display("FAIL copy_status: got %h exp 0002", v); end
        tests++;
        reg_rd(9, v);
        if (v !== 16'd8) begin fails++; $display("FAIL copy_pixdone_lo: got %h exp 0008", v); end
        tests++;
        reg_rd(10, v);
        if (v !== 16'd0) begin fails++; $display("FAIL copy_pixdone_hi: got %h exp 0000", v); end
        tests++;
        if (wr_addr_q.size() !== 8 || rd_addr_q.size() !== 8) begin
            fails++; $display("FAIL copy_count: got %0d writes %0d reads exp 8/8", wr_addr_q.size(), rd_addr_q.size());
        end
        tests++;
        for (int i = 0; i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
            if (rd_addr_q[i] !== 32'h1000 + 32'(i) || wr_addr_q[i] !== 32'h2000 + 32'(i) || wr_data_q[i] !== 8'(17 * (i + 1))) begin
                fails++;
                $display("FAIL copy_px%0d: got rd %h wr %h data %h exp %h %h %h", i, rd_addr_q[i], wr_addr_q[i], wr_data_q[i],
                         32'h1000 + 32'(i), 32'h2000 + 32'(i), 8'(17 * (i + 1)));
            end
            tests++;
        end
    endtask

    task automatic test_modes;
        logic [15:0] v;
        logic [7:0] exp_t [3];
        int n;
        exp_t[0] = 8'h00; exp_t[1] = 8'hFF; exp_t[2] = 8'hFF;
        mem[16'h1100] = 8'h7F; mem[16'h1101] = 8'h80; mem[16'h1102] = 8'hFF;
        reg_wr(8, 16'h0080);
        cfg(32'h1100, 32'h2100, 16'd3, 16'd1);
        reg_wr(0, 16'h0009);
        reg_rd(0, v);
        if (v !== 16'h0008) begin fails++; $display("FAIL ctrl_readback: got %h exp 0008", v); end
        tests++;
        wait_idle(100, n);
        if (wr_data_q.size() !== 3) begin fails++; $display("FAIL thresh_count: got %0d exp 3", wr_data_q.size()); end
        tests++;
        for (int i = 0; i < wr_data_q.size() && i < 3; i++) begin
            if (wr_data_q[i] !== exp_t[i]) begin fails++; $display("FAIL thresh_px%0d: got %h exp %h", i, wr_data_q[i], exp_t[i]); end
            tests++;
        end
        mem[16'h1200] = 8'h5A;
        cfg(32'h1200, 32'h2200, 16'd1, 16'd1);
        reg_wr(0, 16'h0005);
        wait_idle(100, n);
        if (wr_data_q.size() !== 1 || wr_data_q[0] !== 8'hA5 || wr_addr_q[0] !== 32'h2200) begin
            fails++; $display("FAIL invert: got n=%0d data %h exp n=1 data a5 @2200", wr_data_q.size(), wr_data_q[0]);
        end
        tests++;
        cfg(32'h1200, 32'h2201, 16'd1, 16'd1);
        reg_wr(0, 16'h000D);
        wait_idle(100, n);
        if (wr_data_q.size() !== 1 || wr_data_q[0] !== 8'h5A) begin
            fails++; $display("FAIL mode3_copy: got n=%0d data %h exp n=1 data 5a", wr_data_q.size(), wr_data_q[0]);
        end
        tests++;
        reg_wr(0, 16'h0000);
    endtask

    task automatic test_stall;
        logic [15:0] v;
        int n;
        cfg(32'h1000, 32'h3000, 16'd4, 16'd2);
        stall_viol = 0;
        stall_en = 1'b1;
        reg_wr(0, 16'h0001);
        wait_idle(300, n);
        stall_en = 1'b0;
        if (stall_viol !== 0) begin fails++; $display("FAIL stall_stable: got %0d violations exp 0", stall_viol); end
        tests++;
        if (wr_data_q.size() !== 8) begin fails++; $display("FAIL stall_count: got %0d exp 8", wr_data_q.size()); end
        tests++;
        for (int i = 0; i < wr_data_q.size(); i++) begin
            if (wr_addr_q[i] !== 32'h3000 + 32'(i) || wr_data_q[i] !== 8'(17 * (i + 1))) begin
                fails++; $display("FAIL stall_px%0d: got %h@%h exp %h@%h", i, wr_data_q[i], wr_addr_q[i], 8'(17 * (i + 1)), 32'h3000 + 32'(i));
            end
            tests++;
        end
        reg_rd(9, v);
        if (v !== 16'd8) begin fails++; $display("FAIL stall_pixdone: got %h exp 0008", v); end
        tests++;
    endtask

    task automatic test_abort;
        logic [15:0] v;
        int n, k;
        cfg(32'h1000, 32'h4000, 16'd4, 16'd2);
        reg_wr(0, 16'h0001);
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!(m_wr && wr_addr_q.size() == 2) && k < 100);
        if (k >= 100) begin fails++; $display("FAIL abort_reach_write: got timeout exp third write"); end
        tests++;
        force_wait = 1'b1;
        reg_wr(0, 16'h0002);
        repeat (3) @(negedge clk);
        if (m_wr !== 1'b1 || m_addr !== 32'h4002 || m_wdata !== 8'h33) begin
            fails++; $display("FAIL abort_held: got wr=%b %h@%h exp 1 33@4002", m_wr, m_wdata, m_addr);
        end
        tests++;
        reg_rd(1, v);
        if (v !== 16'h0001) begin fails++; $display("FAIL abort_pending_status: got %h exp 0001", v); end
        tests++;
        @(posedge clk); #1 force_wait = 1'b0;
        wait_idle(20, n);
        reg_rd(1, v);
        if (v !== 16'h0004) begin fails++; $display("FAIL abort_status: got %h exp 0004", v); end
        tests++;
        reg_rd(9, v);
        if (v !== 16'd3) begin fails++; $display("FAIL abort_pixdone: got %h exp 0003", v); end
        tests++;
        if (wr_addr_q.size() !== 3 || wr_data_q[2] !== 8'h33) begin
            fails++; $display("FAIL abort_writes: got %0d last %h exp 3 last 33", wr_addr_q.size(), wr_data_q[wr_data_q.size() - 1]);
        end
        tests++;
        reg_wr(0, 16'h0002);
        reg_wr(1, 16'h0000);
        reg_rd(1, v);
        if (v !== 16'h0004) begin fails++; $display("FAIL w1c_zero: got %h exp 0004", v); end
        tests++;
        reg_wr(1, 16'h0004);
        reg_rd(1, v);
        if (v !== 16'h0000) begin fails++; $display("FAIL w1c_aborted: got %h exp 0000", v); end
        tests++;
    endtask

    task automatic test_edge_cases;
        logic [15:0] v;
        int n, s0;
        cfg(32'h1000, 32'h5000, 16'd0, 16'd2);
        s0 = strobes;
        reg_wr(0, 16'h0001);
        reg_rd(1, v);
        if (v !== 16'h0002) begin fails++; $display("FAIL zero_done: got %h exp 0002", v); end
        tests++;
        repeat (3) @(negedge clk);
        if (strobes !== s0) begin fails++; $display("FAIL zero_strobes: got %0d exp %0d", strobes, s0); end
        tests++;
        cfg(32'h1000, 32'h5000, 16'd2, 16'd1);
        reg_wr(0, 16'h0003);
        repeat (3) @(negedge clk);
        reg_rd(1, v);
        if (v !== 16'h0000 || strobes !== s0) begin fails++; $display("FAIL go_abort: got status %h strobes %0d exp 0000 %0d", v, strobes, s0); end
        tests++;
        for (int i = 0; i < 4; i++) mem[16'h1300 + 16'(i)] = 8'hC1 + 8'(i);
        cfg(32'h1300, 32'h2300, 16'd4, 16'd1);
        reg_wr(0, 16'h0001);
        reg_wr(2, 16'h1400);
        reg_wr(0, 16'h0001);
        wait_idle(100, n);
        if (wr_addr_q.size() !== 4 || rd_addr_q.size() !== 4) begin
            fails++; $display("FAIL go_busy_count: got %0d/%0d exp 4/4", wr_addr_q.size(), rd_addr_q.size());
        end
        tests++;
        reg_rd(2, v);
        if (v !== 16'h1300) begin fails++; $display("FAIL busy_cfg_ignored: got %h exp 1300", v); end
        tests++;
        reg_rd(9, v);
        if (v !== 16'd4) begin fails++; $display("FAIL go_busy_pixdone: got %h exp 0004", v); end
        tests++;
        mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hA2; mem[16'h0000] = 8'hA3; mem[16'h0001] = 8'hA4;
        cfg(32'hFFFF_FFFE, 32'h2400, 16'd4, 16'd1);
        reg_wr(0, 16'h0001);
        wait_idle(100, n);
        if (rd_addr_q.size() !== 4) begin fails++; $display("FAIL wrap_count: got %0d exp 4", rd_addr_q.size()); end
        tests++;
        for (int i = 0; i < rd_addr_q.size() && i < wr_data_q.size(); i++) begin
            if (rd_addr_q[i] !== 32'hFFFF_FFFE + 32'(i) || wr_data_q[i] !== 8'hA1 + 8'(i)) begin
                fails++; $display("FAIL wrap_px%0d: got %h from %h exp %h from %h", i, wr_data_q[i], rd_addr_q[i], 8'hA1 + 8'(i), 32'hFFFF_FFFE + 32'(i));
            end
            tests++;
        end
        reg_wr(11, 16'h0003);
        reg_rd(11, v);
`ifdef EDGE_ACCEL_IRQ_EN
        if (v !== 16'h0003) begin fails++; $display("FAIL reg11: got %h exp 0003", v); end
`else
        if (v !== 16'h0000) begin fails++; $display("FAIL reg11: got %h exp 0000", v); end
`endif
        tests++;
        reg_wr(11, 16'h0000);
        reg_wr(12, 16'hFFFF);
        reg_rd(12, v);
        if (v !== 16'h0000) begin fails++; $display("FAIL reg12: got %h exp 0000", v); end
        tests++;
    endtask

    task automatic test_wide;
        logic [15:0] v;
        int n;
        cfg(32'h0100, 32'h0200, 16'd3, 16'd1);
        reg_wr(0, 16'h0001);
        wait_idle(100, n);
        repeat (2) @(negedge clk);
        if (w32_addr_q.size() !== 3) begin fails++; $display("FAIL wide_count: got %0d exp 3", w32_addr_q.size()); end
        tests++;
        for (int i = 0; i < w32_addr_q.size(); i++) begin
            if (w32_addr_q[i] !== 32'h200 + 32'(4 * i) || w32_data_q[i] !== {16'h0100 + 16'(4 * i), 16'hBEEF}) begin
                fails++; $display("FAIL wide_px%0d: got %h@%h exp %h@%h", i, w32_data_q[i], w32_addr_q[i],
                                  {16'h0100 + 16'(4 * i), 16'hBEEF}, 32'h200 + 32'(4 * i));
            end
            tests++;
        end
        s_addr = 4'd9;
        #1 v = s_rdata32;
        if (v !== 16'd3) begin fails++; $display("FAIL wide_pixdone: got %h exp 0003", v); end
        tests++;
    endtask

`ifdef EDGE_ACCEL_IRQ_EN
    task automatic test_irq;
        int n;
        cfg(32'h1000, 32'h2000, 16'd2, 16'd1);
        reg_wr(11, 16'h0001);
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b exp 0", irq); end
        tests++;
        reg_wr(0, 16'h0001);
        wait_idle(100, n);
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_done: got %b exp 1", irq); end
        tests++;
        reg_wr(1, 16'h0002);
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b exp 0", irq); end
        tests++;
        reg_wr(11, 16'h0000);
    endtask
`endif

    task automatic test_reset_mid_job;
        logic [15:0] v;
        int s0;
        cfg(32'h1000, 32'h6000, 16'd4, 16'd2);
        reg_wr(0, 16'h0001);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if ({m_rd, m_wr} !== 2'b00) begin fails++; $display("FAIL rst_mid_strobes: got %b exp 00", {m_rd, m_wr}); end
        tests++;
        reg_rd(1, v);
        if (v !== 16'h0000) begin fails++; $display("FAIL rst_mid_status: got %h exp 0000", v); end
        tests++;
        rst = 1'b0;
        s0 = strobes;
        repeat (4) @(negedge clk);
        reg_rd(2, v);
        if (strobes !== s0 || v !== 16'h0000) begin fails++; $display("FAIL rst_mid_lost: got strobes %0d src %h exp %0d 0000", strobes, v, s0); end
        tests++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_copy;
        test_modes;
        test_stall;
        test_abort;
        test_edge_cases;
        test_wide;
`ifdef EDGE_ACCEL_IRQ_EN
        test_irq;
`endif
        test_reset_mid_job;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
